// File: rtl/srsw_stream_fifo.sv
// Streaming FIFO in front of a registered-read single-port-pair RAM.
// A two-entry output buffer hides the one-cycle RAM read latency so a word can move every cycle.
module srsw_stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH+1:0] count
);

  localparam logic [ADDR_WIDTH:0]   USED_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1'b1);

  logic [ADDR_WIDTH-1:0] wptr_r;
  logic [ADDR_WIDTH-1:0] rptr_r;
  logic [ADDR_WIDTH:0]   ram_used_r;
  logic                  inflight_r;
  logic [1:0]            buf_cnt_r;
  logic [DATA_WIDTH-1:0] buf0_r;
  logic [DATA_WIDTH-1:0] buf1_r;

  logic       push_s;
  logic       pop_s;
  logic       cap_s;
  logic       readable_s;
  logic       ren_s;
  logic [2:0] occ_s;

  // Handshakes and read scheduling; ram_used can only reach DEPTH, so its MSB flags full.
  always_comb begin
    push_s     = in_valid & ~ram_used_r[ADDR_WIDTH] & resetn;
    pop_s      = (buf_cnt_r != 2'd0) & out_ready;
    cap_s      = inflight_r;
    readable_s = ram_used_r > {{ADDR_WIDTH{1'b0}}, inflight_r};
    // Counting this cycle's pop keeps the pipeline full at one word per cycle.
    occ_s      = {1'b0, buf_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    ren_s      = readable_s & (occ_s < 3'd2);
  end

  assign in_ready  = ~ram_used_r[ADDR_WIDTH];
  assign ram_wen   = push_s;
  assign ram_waddr = wptr_r;
  assign ram_wdata = in_data;
  assign ram_ren   = ren_s;
  assign ram_raddr = rptr_r;
  assign out_valid = buf_cnt_r != 2'd0;
  assign out_data  = out_valid ? buf0_r : {DATA_WIDTH{1'b0}};
  assign count     = {1'b0, ram_used_r} + {{ADDR_WIDTH{1'b0}}, buf_cnt_r};

  // RAM pointers, occupancy of the RAM and the read-in-flight flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr_r     <= {ADDR_WIDTH{1'b0}};
      rptr_r     <= {ADDR_WIDTH{1'b0}};
      ram_used_r <= {(ADDR_WIDTH+1){1'b0}};
      inflight_r <= 1'b0;
    end else begin
      if (push_s) wptr_r <= wptr_r + PTR_ONE;
      else        wptr_r <= wptr_r;
      if (ren_s)  rptr_r <= rptr_r + PTR_ONE;
      else        rptr_r <= rptr_r;
      inflight_r <= ren_s;
      case ({push_s, cap_s})
        2'b10:   ram_used_r <= ram_used_r + USED_ONE;
        2'b01:   ram_used_r <= ram_used_r - USED_ONE;
        default: ram_used_r <= ram_used_r;
      endcase
    end
  end

  // Output buffer: rdata is sampled only in the capture cycle, buf0 is always the head.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      buf_cnt_r <= 2'd0;
      buf0_r    <= {DATA_WIDTH{1'b0}};
      buf1_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      case ({cap_s, pop_s})
        2'b10: begin
          buf_cnt_r <= buf_cnt_r + 2'd1;
          if (buf_cnt_r == 2'd0) buf0_r <= ram_rdata;
          else                   buf1_r <= ram_rdata;
        end
        2'b01: begin
          buf_cnt_r <= buf_cnt_r - 2'd1;
          buf0_r    <= buf1_r;
        end
        2'b11: begin
          if (buf_cnt_r == 2'd1) begin
            buf0_r <= ram_rdata;
          end else begin
            buf0_r <= buf1_r;
            buf1_r <= ram_rdata;
          end
        end
        default: begin
          buf_cnt_r <= buf_cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srsw_stream_fifo.sv
// Directed bench for srsw_stream_fifo: vector table plus reset, wrap, stall and clock-gating sequences.
// Stimulus changes on fall times; every step samples 4 time units later, one unit before a possible rise.
module tb_srsw_stream_fifo;

  localparam int DW = 32;
  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          clk_en = 1'b1;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          ram_wen;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_ren;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic [AW+1:0] count;

  srsw_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .count(count)
  );

  // Gated clock: a rise is skipped while clk_en is low.
  always begin
    #5;
    if (clk_en) clock = 1'b1;
    #5;
    clock = 1'b0;
  end

  // RAM model: rdata follows the stored slot of the last registered address, so rewrites show through.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] raddr_q;
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    raddr_q = 2'd0;
  end
  always @(posedge clock) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) raddr_q <= ram_raddr;
  end
  assign ram_rdata = mem[raddr_q];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q [$];
  int pop_total;
  int first_pop_cyc;
  int last_pop_cyc;
  logic [DW-1:0] last_pop_data;
  logic stall_armed = 1'b0;
  logic [DW-1:0] stall_data;
  logic halted_prev = 1'b0;
  logic [AW+1:0] prev_count;
  logic s_ir, s_ov, s_wen, s_ren;
  logic [DW-1:0] s_od;
  logic [AW+1:0] s_cnt;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at step %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // One clock step: sample, run the scoreboard for an edge that will occur, then move to the next fall time.
  task automatic step();
    logic [DW-1:0] e;
    #4;
    s_ir = in_ready; s_ov = out_valid; s_od = out_data; s_cnt = count;
    s_wen = ram_wen; s_ren = ram_ren;
    if (resetn && stall_armed) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", out_data, stall_data);
    end
    if (resetn && halted_prev) chk("gated_count", {28'd0, count}, {28'd0, prev_count});
    if (resetn && clk_en) begin
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", out_data, 32'hDEAD_BEEF);
        end else begin
          e = exp_q.pop_front();
          chk("order", out_data, e);
        end
        pop_total++;
        last_pop_cyc = cyc;
        last_pop_data = out_data;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
    end
    stall_armed = resetn && out_valid && !out_ready;
    stall_data  = out_data;
    halted_prev = resetn && !clk_en;
    prev_count  = count;
    #6;
    cyc++;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1; clk_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (exp_q.size() == 0 && count == 4'd0) break;
      step();
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("drain_count", {28'd0, count}, 32'd0);
  endtask

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          exp_ir;
    logic          exp_ov;
    logic [DW-1:0] exp_od;
    logic [AW+1:0] exp_cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [0:NV-1];

  initial begin
    // single word latency, then fill with out_ready low and release
    vecs[0]  = '{1'b1, 32'h11, 1'b1, 1'b1, 1'b0, 32'h00, 4'd0};
    vecs[1]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 4'd1};
    vecs[2]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 4'd1};
    vecs[3]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h11, 4'd1};
    vecs[4]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 4'd0};
    vecs[5]  = '{1'b1, 32'h01, 1'b0, 1'b1, 1'b0, 32'h00, 4'd0};
    vecs[6]  = '{1'b1, 32'h02, 1'b0, 1'b1, 1'b0, 32'h00, 4'd1};
    vecs[7]  = '{1'b1, 32'h03, 1'b0, 1'b1, 1'b0, 32'h00, 4'd2};
    vecs[8]  = '{1'b1, 32'h04, 1'b0, 1'b1, 1'b1, 32'h01, 4'd3};
    vecs[9]  = '{1'b1, 32'h05, 1'b0, 1'b1, 1'b1, 32'h01, 4'd4};
    vecs[10] = '{1'b1, 32'h06, 1'b0, 1'b1, 1'b1, 32'h01, 4'd5};
    vecs[11] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'h01, 4'd6};
    vecs[12] = '{1'b1, 32'h77, 1'b0, 1'b0, 1'b1, 32'h01, 4'd6};
    vecs[13] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h01, 4'd6};
    vecs[14] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h02, 4'd5};
    vecs[15] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h03, 4'd4};
    vecs[16] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h04, 4'd3};
    vecs[17] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h05, 4'd2};
    vecs[18] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h06, 4'd1};
    vecs[19] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 4'd0};

    resetn = 1'b0; in_valid = 1'b1; in_data = 32'h5A; out_ready = 1'b1;
    pop_total = 0; first_pop_cyc = -1; last_pop_cyc = -1; last_pop_data = 32'h0;
    step();
    step();
    chk("rst_in_ready", {31'd0, s_ir}, 32'd1);
    chk("rst_out_valid", {31'd0, s_ov}, 32'd0);
    chk("rst_out_data", s_od, 32'd0);
    chk("rst_count", {28'd0, s_cnt}, 32'd0);
    chk("rst_ram_wen", {31'd0, s_wen}, 32'd0);
    chk("rst_ram_ren", {31'd0, s_ren}, 32'd0);
    in_valid = 1'b0;
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      in_valid = vecs[i].iv; in_data = vecs[i].id; out_ready = vecs[i].ordy;
      step();
      chk($sformatf("vec%0d_in_ready", i), {31'd0, s_ir}, {31'd0, vecs[i].exp_ir});
      chk($sformatf("vec%0d_out_valid", i), {31'd0, s_ov}, {31'd0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_out_data", i), s_od, vecs[i].exp_od);
      chk($sformatf("vec%0d_count", i), {28'd0, s_cnt}, {28'd0, vecs[i].exp_cnt});
      chk($sformatf("vec%0d_ram_wen", i), {31'd0, s_wen}, {31'd0, vecs[i].iv & vecs[i].exp_ir});
    end

    // 20 back-to-back words: 5 pointer wraps, 3-cycle latency then one word per cycle
    pop_total = 0; first_pop_cyc = -1;
    begin
      int push_start;
      push_start = cyc;
      for (int i = 0; i < 20; i++) begin
        in_valid = 1'b1; in_data = 32'h100 + i; out_ready = 1'b1;
        step();
        chk("stream_in_ready", {31'd0, s_ir}, 32'd1);
      end
      drain();
      chk("stream_pops", pop_total, 32'd20);
      chk("stream_latency", first_pop_cyc - push_start, 32'd3);
      chk("stream_rate", last_pop_cyc - first_pop_cyc, 32'd19);
    end

    // random backpressure against a RAM whose captured slots get rewritten
    for (int i = 0; i < 80; i++) begin
      in_valid = 1'($urandom_range(0, 1)); in_data = $urandom;
      out_ready = ($urandom_range(0, 2) == 0);
      step();
    end
    drain();

    // reset with three words held and one read in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h31 + i;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("pre_reset_count", {28'd0, s_cnt}, 32'd3);
    resetn = 1'b0;
    step();
    chk("mid_reset_out_valid", {31'd0, s_ov}, 32'd0);
    chk("mid_reset_count", {28'd0, s_cnt}, 32'd0);
    chk("mid_reset_in_ready", {31'd0, s_ir}, 32'd1);
    chk("mid_reset_ram_ren", {31'd0, s_ren}, 32'd0);
    exp_q.delete();
    resetn = 1'b1;
    in_valid = 1'b1; in_data = 32'hAA; out_ready = 1'b1;
    pop_total = 0; first_pop_cyc = -1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("post_reset_pops", pop_total, 32'd1);
    chk("post_reset_first", last_pop_data, 32'hAA);

    // random clock halts: accepted words must come out in the ungated order
    pop_total = 0;
    for (int i = 0; i < 80; i++) begin
      clk_en = ($urandom_range(0, 2) != 0);
      in_valid = 1'($urandom_range(0, 1)); in_data = $urandom;
      out_ready = ($urandom_range(0, 1) == 1);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
